execute_mul_sequencer: RTL and testbench

- Sits in front of the execute-stage ALU and shares it between two users: the normal pipeline ALU ops and a multi-cycle 16x16 shift-add multiply.
- When idle, pipeline operands and controls pass straight through to the ALU.
- On a multiply request, the block stalls the pipeline, borrows the ALU for iterative ADD micro-ops and suppresses flag updates.
- It then returns the low 16 bits of the product.

---
 rtl/execute_mul_sequencer.sv | 133 +++++++++++++
 tb/tb_execute_mul_sequencer.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/execute_mul_sequencer.sv
// Shares the execute-stage ALU between pipeline ops and a 16x16 shift-add multiply.
// Define MUL_EARLY_EXIT_EN to finish once the remaining multiplier bits are all zero.
module execute_mul_sequencer #(
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned CNT_W      = 4,
    parameter logic [1:0]  ADD_MODE   = 2'b00,
    parameter logic [1:0]  CARRY_KEEP = 2'b00
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pipe_valid,
    input  logic             mul_start,
    input  logic             flush,
    input  logic [WIDTH-1:0] Op1,
    input  logic [WIDTH-1:0] Op2,
    input  logic [1:0]       ALUmode,
    input  logic [1:0]       carrySelect,
    input  logic [WIDTH-1:0] alu_result,
    output logic [WIDTH-1:0] alu_Op1,
    output logic [WIDTH-1:0] alu_Op2,
    output logic [1:0]       alu_ALUmode,
    output logic [1:0]       alu_carrySelect,
    output logic             ccr_we,
    output logic             stall,
    output logic [WIDTH-1:0] mul_result,
    output logic             mul_valid
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [CNT_W-1:0] count;

    logic [WIDTH-1:0] acc_next;
    logic [WIDTH-1:0] mplier_next;
    logic             last_iter;

    always_comb begin
        acc_next    = mplier[0] ? alu_result : acc;
        mplier_next = mplier >> 1;
`ifdef MUL_EARLY_EXIT_EN
        last_iter   = (count == CNT_W'(WIDTH - 1)) || (mplier_next == '0);
`else
        last_iter   = (count == CNT_W'(WIDTH - 1));
`endif
    end

    // ALU steering and pipeline handshakes follow state only, so reset drops stall at once.
    always_comb begin
        alu_Op1         = Op1;
        alu_Op2         = Op2;
        alu_ALUmode     = ALUmode;
        alu_carrySelect = carrySelect;
        ccr_we          = 1'b0;
        stall           = 1'b0;
        case (state)
            IDLE: begin
                ccr_we = pipe_valid & ~mul_start;
                stall  = mul_start;
            end
            RUN: begin
                alu_Op1         = acc;
                alu_Op2         = mcand;
                alu_ALUmode     = ADD_MODE;
                alu_carrySelect = CARRY_KEEP;
                stall           = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            acc        <= '0;
            mcand      <= '0;
            mplier     <= '0;
            count      <= '0;
            mul_result <= '0;
            mul_valid  <= 1'b0;
        end else begin
            mul_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (mul_start && !flush) begin
                        acc    <= '0;
                        mcand  <= Op1;
                        mplier <= Op2;
                        count  <= '0;
`ifdef MUL_EARLY_EXIT_EN
                        if (Op2 == '0) begin
                            state      <= DONE;
                            mul_result <= '0;
                            mul_valid  <= 1'b1;
                        end else begin
                            state <= RUN;
                        end
`else
                        state <= RUN;
`endif
                    end
                end
                RUN: begin
                    if (flush) begin
                        state <= IDLE;
                        acc   <= '0;
                    end else begin
                        acc    <= acc_next;
                        mcand  <= mcand << 1;
                        mplier <= mplier_next;
                        count  <= count + 1'b1;
                        // Result is captured from the final accumulate so it is ready in DONE.
                        if (last_iter) begin
                            state      <= DONE;
                            mul_result <= acc_next;
                            mul_valid  <= 1'b1;
                        end
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_execute_mul_sequencer.sv
// Self-checking bench for execute_mul_sequencer: pass-through vector table plus
// scoreboarded multiplies, reset and flush corner cases.
module tb_execute_mul_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        pipe_valid;
    logic        mul_start;
    logic        flush;
    logic [15:0] Op1;
    logic [15:0] Op2;
    logic [1:0]  ALUmode;
    logic [1:0]  carrySelect;
    logic [15:0] alu_result;
    logic [15:0] alu_Op1;
    logic [15:0] alu_Op2;
    logic [1:0]  alu_ALUmode;
    logic [1:0]  alu_carrySelect;
    logic        ccr_we;
    logic        stall;
    logic [15:0] mul_result;
    logic        mul_valid;

    execute_mul_sequencer #(
        .WIDTH(16),
        .CNT_W(4),
        .ADD_MODE(2'b00),
        .CARRY_KEEP(2'b00)
    ) dut (
        .clk(clk),
        .reset(reset),
        .pipe_valid(pipe_valid),
        .mul_start(mul_start),
        .flush(flush),
        .Op1(Op1),
        .Op2(Op2),
        .ALUmode(ALUmode),
        .carrySelect(carrySelect),
        .alu_result(alu_result),
        .alu_Op1(alu_Op1),
        .alu_Op2(alu_Op2),
        .alu_ALUmode(alu_ALUmode),
        .alu_carrySelect(alu_carrySelect),
        .ccr_we(ccr_we),
        .stall(stall),
        .mul_result(mul_result),
        .mul_valid(mul_valid)
    );

    always #5 clk = ~clk;

    // Execute ALU model: plain 16-bit adder, carry-out dropped.
    assign alu_result = alu_Op1 + alu_Op2;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [15:0] prod;
        int          lat;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic        pv;
        logic [15:0] o1;
        logic [15:0] o2;
        logic [1:0]  mode;
        logic [1:0]  csel;
        logic        exp_ccr;
    } pt_vec_t;
    pt_vec_t pt[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int exp_lat(input logic [15:0] b);
        int m;
        m = 0;
`ifdef MUL_EARLY_EXIT_EN
        if (b == 16'h0) return 1;
        for (int i = 0; i < 16; i++) if (b[i]) m = i;
        return 2 + m;
`else
        return 17 + m;
`endif
    endfunction

    // Drives T0; when expect_done is set, the expected product goes to the scoreboard.
    task automatic start_mul(input logic [15:0] a, input logic [15:0] b,
                             input logic pv, input bit expect_done);
        exp_t e;
        logic [15:0] p;
        @(negedge clk);
        Op1 = a;
        Op2 = b;
        mul_start = 1'b1;
        pipe_valid = pv;
        ALUmode = 2'b11;
        carrySelect = 2'b10;
        #1;
        chk("stall_t0", stall, 1);
        chk("ccr_we_t0", ccr_we, 0);
        p = a * b;
        e.prod = p;
        e.lat = exp_lat(b);
        if (expect_done) sb.push_back(e);
        @(posedge clk);
    endtask

    task automatic wait_result();
        exp_t e;
        bit got;
        got = 0;
        if (sb.size() == 0) begin
            chk("sb_empty", 1, 0);
            return;
        end
        e = sb.pop_front();
        for (int cyc = 1; cyc <= 40 && !got; cyc++) begin
            @(negedge clk);
            mul_start = 1'b0;
            pipe_valid = 1'b0;
            #1;
            if (mul_valid) begin
                got = 1;
                chk("latency", cyc, e.lat);
                chk("mul_result", mul_result, e.prod);
                chk("stall_done", stall, 0);
                chk("ccr_we_done", ccr_we, 0);
            end else begin
                chk("stall_run", stall, 1);
                chk("ccr_we_run", ccr_we, 0);
                chk("alu_mode_run", alu_ALUmode, 2'b00);
                chk("alu_csel_run", alu_carrySelect, 2'b00);
            end
        end
        if (!got) chk("timeout", 1, 0);
        @(negedge clk);
        #1;
        chk("valid_one_cycle", mul_valid, 0);
        chk("result_hold", mul_result, e.prod);
    endtask

    task automatic expect_quiet(input int n, input string name);
        bit seen;
        seen = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            #1;
            if (mul_valid) seen = 1;
        end
        chk(name, seen, 0);
    endtask

    initial begin
        int rst_at;
        logic [15:0] ra;
        logic [15:0] rb;

        pt[0] = '{1'b1, 16'd15,   16'd24,   2'b00, 2'b10, 1'b1};
        pt[1] = '{1'b0, 16'hA5A5, 16'h5A5A, 2'b01, 2'b01, 1'b0};
        pt[2] = '{1'b1, 16'hFFFF, 16'h0000, 2'b11, 2'b11, 1'b1};
        pt[3] = '{1'b1, 16'h1234, 16'h8001, 2'b10, 2'b00, 1'b1};

        reset = 1'b1;
        pipe_valid = 1'b0;
        mul_start = 1'b0;
        flush = 1'b0;
        Op1 = '0;
        Op2 = '0;
        ALUmode = '0;
        carrySelect = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_stall", stall, 0);
        chk("rst_mul_valid", mul_valid, 0);
        chk("rst_mul_result", mul_result, 0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            pipe_valid = pt[i].pv;
            mul_start = 1'b0;
            Op1 = pt[i].o1;
            Op2 = pt[i].o2;
            ALUmode = pt[i].mode;
            carrySelect = pt[i].csel;
            #1;
            chk("pt_op1", alu_Op1, pt[i].o1);
            chk("pt_op2", alu_Op2, pt[i].o2);
            chk("pt_mode", alu_ALUmode, pt[i].mode);
            chk("pt_csel", alu_carrySelect, pt[i].csel);
            chk("pt_ccr_we", ccr_we, pt[i].exp_ccr);
            chk("pt_stall", stall, 0);
        end

        start_mul(16'd15, 16'd24, 1'b0, 1'b1);
        wait_result();
        chk("basic_value", mul_result, 16'h0168);
        start_mul(16'hFFFF, 16'hFFFF, 1'b0, 1'b1);
        wait_result();
        chk("wrap_value", mul_result, 16'h0001);
        start_mul(16'h1234, 16'h0000, 1'b1, 1'b1);
        wait_result();
        for (int i = 0; i < 4; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            start_mul(ra, rb, 1'b0, 1'b1);
            wait_result();
        end
        start_mul(16'h00FF, 16'h8000, 1'b0, 1'b1);
        wait_result();

`ifdef MUL_EARLY_EXIT_EN
        rst_at = 3;
`else
        rst_at = 8;
`endif
        start_mul(16'd7, 16'd9, 1'b0, 1'b0);
        for (int c = 1; c <= rst_at; c++) begin
            @(negedge clk);
            mul_start = 1'b0;
        end
        #1;
        reset = 1'b1;
        #1;
        chk("rst_mid_stall", stall, 0);
        chk("rst_mid_valid", mul_valid, 0);
        @(negedge clk);
        reset = 1'b0;
        expect_quiet(20, "rst_no_valid");
        start_mul(16'd7, 16'd9, 1'b0, 1'b1);
        wait_result();
        chk("after_rst_value", mul_result, 16'h003F);

        start_mul(16'd5, 16'h8000, 1'b0, 1'b0);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            mul_start = 1'b0;
        end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        #1;
        chk("flush_stall_t6", stall, 0);
        chk("flush_valid_t6", mul_valid, 0);
        expect_quiet(20, "flush_no_valid");
        chk("flush_result_kept", mul_result, 16'h003F);

        @(negedge clk);
        flush = 1'b1;
        mul_start = 1'b1;
        Op1 = 16'd3;
        Op2 = 16'd3;
        @(negedge clk);
        flush = 1'b0;
        mul_start = 1'b0;
        #1;
        chk("idle_flush_no_accept", stall, 0);
        expect_quiet(20, "idle_flush_no_valid");

        start_mul(16'd3, 16'd5, 1'b0, 1'b1);
        wait_result();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
